// File: rtl/roteamento_pkg.sv
// Shared types and constants for the routing path: word width, arbiter states, source ids.
package roteamento_pkg;

   localparam int unsigned N = 4;

   typedef logic [N-1:0] palavra_t;

   typedef enum logic {
      OCIOSO = 1'b0,
      ENVIA  = 1'b1
   } estado_t;

   localparam logic FONTE_A = 1'b0;
   localparam logic FONTE_B = 1'b1;

endpackage

// File: rtl/arbitro_roteamento_buffer_entrada.sv
// One-entry input buffer: accepts a word on req && ack, holds it until the arbiter clears it.
module buffer_entrada
   import roteamento_pkg::*;
(
   input  logic     clock,
   input  logic     reset,
   input  palavra_t palavra,
   input  logic     req,
   output logic     ack,
   input  logic     limpa,
   output logic     cheio,
   output palavra_t dado
);

   // ack is kept as the registered complement of cheio; a drain never coincides with a capture
   always_ff @(posedge clock) begin
      if (reset) begin
         cheio <= 1'b0;
         ack   <= 1'b1;
         dado  <= '0;
      end else if (limpa) begin
         cheio <= 1'b0;
         ack   <= 1'b1;
      end else if (req && ack) begin
         cheio <= 1'b1;
         ack   <= 1'b0;
         dado  <= palavra;
      end
   end

endmodule

// File: rtl/arbitro_roteamento.sv
// Round-robin arbiter feeding the 2:1 routing channel from two one-entry source buffers.
// Optional per-source consumed-word counters when ROTEAMENTO_CONTADORES_EN is defined.
module arbitro_roteamento
   import roteamento_pkg::*;
(
   input  logic     clock,
   input  logic     reset,
   input  palavra_t A,
   input  logic     req_a,
   output logic     ack_a,
   input  palavra_t B,
   input  logic     req_b,
   output logic     ack_b,
   output logic     SEL,
   output palavra_t Saida,
   output logic     saida_valida,
   input  logic     canal_pronto
`ifdef ROTEAMENTO_CONTADORES_EN
   ,
   output logic [7:0] cont_a,
   output logic [7:0] cont_b
`endif
);

   logic     cheio_a, cheio_b;
   logic     limpa_a, limpa_b;
   palavra_t dado_a, dado_b;

   estado_t  estado, estado_n;
   logic     ponteiro, ponteiro_n;
   logic     sel_n;
   palavra_t saida_n;
   logic     carrega;

   buffer_entrada u_buf_a (
      .clock   (clock),
      .reset   (reset),
      .palavra (A),
      .req     (req_a),
      .ack     (ack_a),
      .limpa   (limpa_a),
      .cheio   (cheio_a),
      .dado    (dado_a)
   );

   buffer_entrada u_buf_b (
      .clock   (clock),
      .reset   (reset),
      .palavra (B),
      .req     (req_b),
      .ack     (ack_b),
      .limpa   (limpa_b),
      .cheio   (cheio_b),
      .dado    (dado_b)
   );

   // Load a new word when the channel is empty or the current word is consumed this cycle
   always_comb begin
      estado_n   = estado;
      ponteiro_n = ponteiro;
      saida_n    = Saida;
      sel_n      = SEL;
      limpa_a    = 1'b0;
      limpa_b    = 1'b0;
      carrega    = (estado == OCIOSO) || canal_pronto;

      if (carrega) begin
         if (cheio_a && (!cheio_b || (ponteiro == FONTE_A))) begin
            saida_n    = dado_a;
            sel_n      = FONTE_A;
            limpa_a    = 1'b1;
            ponteiro_n = FONTE_B;
            estado_n   = ENVIA;
         end else if (cheio_b) begin
            saida_n    = dado_b;
            sel_n      = FONTE_B;
            limpa_b    = 1'b1;
            ponteiro_n = FONTE_A;
            estado_n   = ENVIA;
         end else begin
            estado_n   = OCIOSO;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado       <= OCIOSO;
         ponteiro     <= FONTE_A;
         Saida        <= '0;
         SEL          <= FONTE_A;
         saida_valida <= 1'b0;
      end else begin
         estado       <= estado_n;
         ponteiro     <= ponteiro_n;
         Saida        <= saida_n;
         SEL          <= sel_n;
         saida_valida <= (estado_n == ENVIA);
      end
   end

`ifdef ROTEAMENTO_CONTADORES_EN
   // Words consumed by the channel, attributed to the source tagged by SEL
   always_ff @(posedge clock) begin
      if (reset) begin
         cont_a <= 8'd0;
         cont_b <= 8'd0;
      end else if (saida_valida && canal_pronto) begin
         if (SEL == FONTE_B) cont_b <= cont_b + 8'd1;
         else                cont_a <= cont_a + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_arbitro_roteamento.sv
// Self-checking bench for arbitro_roteamento: directed steps plus random traffic against a cycle model.
module tb_arbitro_roteamento;

   logic       clock;
   logic       reset;
   logic [3:0] A, B;
   logic       req_a, req_b;
   logic       ack_a, ack_b;
   logic       SEL;
   logic [3:0] Saida;
   logic       saida_valida;
   logic       canal_pronto;
`ifdef ROTEAMENTO_CONTADORES_EN
   logic [7:0] cont_a, cont_b;
`endif

   arbitro_roteamento dut (
      .clock        (clock),
      .reset        (reset),
      .A            (A),
      .req_a        (req_a),
      .ack_a        (ack_a),
      .B            (B),
      .req_b        (req_b),
      .ack_b        (ack_b),
      .SEL          (SEL),
      .Saida        (Saida),
      .saida_valida (saida_valida),
      .canal_pronto (canal_pronto)
`ifdef ROTEAMENTO_CONTADORES_EN
      ,
      .cont_a       (cont_a),
      .cont_b       (cont_b)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: index 0 = source A, 1 = source B
   bit         m_cheio [2];
   logic [3:0] m_dado  [2];
   bit         m_ptr;
   bit         m_val;
   logic [3:0] m_saida;
   bit         m_sel;
   logic [7:0] m_cont  [2];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelo();
      int         f;
      int         drenado;
      bit         pedidos [2];
      logic [3:0] palavras[2];
      if (reset) begin
         m_cheio = '{0, 0};
         m_dado  = '{4'h0, 4'h0};
         m_ptr   = 0;
         m_val   = 0;
         m_saida = 4'h0;
         m_sel   = 0;
         m_cont  = '{8'd0, 8'd0};
         return;
      end
      pedidos  = '{req_a, req_b};
      palavras = '{A, B};
      if (m_val && canal_pronto) m_cont[m_sel] = m_cont[m_sel] + 8'd1;
      drenado = -1;
      if (!m_val || canal_pronto) begin
         f = -1;
         if (m_cheio[0] && m_cheio[1]) f = int'(m_ptr);
         else if (m_cheio[0])          f = 0;
         else if (m_cheio[1])          f = 1;
         if (f >= 0) begin
            m_saida = m_dado[f];
            m_sel   = 1'(f);
            m_val   = 1;
            m_ptr   = !(1'(f));
            drenado = f;
         end else begin
            m_val = 0;
         end
      end
      for (int s = 0; s < 2; s++) begin
         if (s == drenado) m_cheio[s] = 0;
         else if (pedidos[s] && !m_cheio[s]) begin
            m_cheio[s] = 1;
            m_dado[s]  = palavras[s];
         end
      end
   endtask

   task automatic compara();
      chk("ack_a", 8'(ack_a), 8'(!m_cheio[0]));
      chk("ack_b", 8'(ack_b), 8'(!m_cheio[1]));
      chk("saida_valida", 8'(saida_valida), 8'(m_val));
      chk("SEL", 8'(SEL), 8'(m_sel));
      chk("Saida", 8'(Saida), 8'(m_saida));
`ifdef ROTEAMENTO_CONTADORES_EN
      chk("cont_a", cont_a, m_cont[0]);
      chk("cont_b", cont_b, m_cont[1]);
`endif
   endtask

   task automatic aplica(input bit rst, input bit ra, input bit rb, input bit cp,
                         input logic [3:0] wa, input logic [3:0] wb);
      reset = rst; req_a = ra; req_b = rb; canal_pronto = cp; A = wa; B = wb;
      modelo();
      @(posedge clock);
      #1;
      compara();
   endtask

   initial begin
      bit         esp_sel;
      logic [3:0] retido;
      bit         retido_sel;

      reset = 1; req_a = 0; req_b = 0; canal_pronto = 0; A = 0; B = 0;
      #2;

      // Reset with A requesting
      aplica(1, 1, 0, 0, 4'h5, 4'h0);
      aplica(1, 1, 0, 0, 4'h5, 4'h0);
      chk("rst_valida", 8'(saida_valida), 8'd0);
      chk("rst_sel", 8'(SEL), 8'd0);
      chk("rst_saida", 8'(Saida), 8'd0);
      chk("rst_ack_a", 8'(ack_a), 8'd1);
      aplica(0, 1, 0, 0, 4'h5, 4'h0);
      aplica(0, 0, 0, 0, 4'h5, 4'h0);
      chk("pos_rst_saida", 8'(Saida), 8'h5);
      chk("pos_rst_sel", 8'(SEL), 8'd0);
      chk("pos_rst_valida", 8'(saida_valida), 8'd1);
      aplica(0, 0, 0, 1, 4'h0, 4'h0);

      // Single B word, valid for exactly one cycle
      aplica(0, 0, 1, 1, 4'h0, 4'hA);
      aplica(0, 0, 0, 1, 4'h0, 4'h0);
      chk("b_sel", 8'(SEL), 8'd1);
      chk("b_saida", 8'(Saida), 8'hA);
      chk("b_valida", 8'(saida_valida), 8'd1);
      aplica(0, 0, 0, 1, 4'h0, 4'h0);
      chk("b_ocioso", 8'(saida_valida), 8'd0);

      // Contention: A first, then B
      aplica(0, 1, 1, 1, 4'h3, 4'hC);
      aplica(0, 0, 0, 1, 4'h0, 4'h0);
      chk("cont1_saida", 8'(Saida), 8'h3);
      chk("cont1_sel", 8'(SEL), 8'd0);
      aplica(0, 0, 0, 1, 4'h0, 4'h0);
      chk("cont2_saida", 8'(Saida), 8'hC);
      chk("cont2_sel", 8'(SEL), 8'd1);
      aplica(0, 0, 0, 1, 4'h0, 4'h0);

      // Continuous requests from both: strict alternation starting at A
      aplica(0, 1, 1, 1, 4'h1, 4'h8);
      esp_sel = 0;
      for (int i = 0; i < 10; i++) begin
         aplica(0, 1, 1, 1, 4'(i), 4'(i + 8));
         chk("alt_valida", 8'(saida_valida), 8'd1);
         chk("alt_sel", 8'(SEL), 8'(esp_sel));
         esp_sel = !esp_sel;
      end

      // Back-pressure: output held, both buffers fill
      retido     = m_saida;
      retido_sel = m_sel;
      for (int i = 0; i < 5; i++) begin
         aplica(0, 1, 1, 0, 4'(4 + i), 4'(9 + i));
         chk("bp_saida", 8'(Saida), 8'(retido));
         chk("bp_sel", 8'(SEL), 8'(retido_sel));
      end
      chk("bp_ack_a", 8'(ack_a), 8'd0);
      chk("bp_ack_b", 8'(ack_b), 8'd0);
      for (int i = 0; i < 4; i++) aplica(0, 0, 0, 1, 4'h0, 4'h0);
      chk("bp_drenado", 8'(saida_valida), 8'd0);

      // Reset mid-operation with valid output and both buffers full
      aplica(0, 1, 1, 0, 4'h6, 4'h7);
      aplica(0, 1, 1, 0, 4'h6, 4'h7);
      aplica(0, 1, 1, 0, 4'h6, 4'h7);
      aplica(1, 1, 1, 1, 4'h6, 4'h7);
      chk("rm_valida", 8'(saida_valida), 8'd0);
      chk("rm_saida", 8'(Saida), 8'd0);
      chk("rm_ack_a", 8'(ack_a), 8'd1);
      chk("rm_ack_b", 8'(ack_b), 8'd1);
      aplica(0, 1, 1, 1, 4'h2, 4'hD);
      aplica(0, 0, 0, 1, 4'h0, 4'h0);
      chk("rm_ptr_a", 8'(SEL), 8'd0);
      chk("rm_ptr_saida", 8'(Saida), 8'h2);
      aplica(0, 0, 0, 1, 4'h0, 4'h0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         aplica(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 9) < 7), 4'($urandom), 4'($urandom));
      end

`ifdef ROTEAMENTO_CONTADORES_EN
      // 256 consumed A words wrap cont_a to zero
      aplica(1, 0, 0, 0, 4'h0, 4'h0);
      for (int i = 0; i < 513; i++) aplica(0, 1, 0, 1, 4'(i), 4'h0);
      chk("wrap_cont_a", cont_a, 8'd0);
      chk("wrap_cont_b", cont_b, 8'd0);
      aplica(0, 0, 0, 1, 4'h0, 4'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arbitro_roteamento.md
Name: arbitro_roteamento

Overview:
- Upstream stage of the 4-bit 2:1 routing multiplexer.
- Accepts words from two sources, A and B, each through its own request/acknowledge handshake, and buffers one word per source.
- Arbitrates round-robin between the two buffers.
- Drives a registered SEL plus the selected word onto the single communication channel with a valid/ready handshake.
- SEL identifies which source owns the word currently on Saida, so the downstream mux and receivers can tag it.

Parameters:
- N, 4, data word width in bits (shared with the routing mux).

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- A  input  N  data word from source A
- req_a  input  1  source A offers A this cycle
- ack_a  output  1  buffer A can accept; transfer when req_a && ack_a
- B  input  N  data word from source B
- req_b  input  1  source B offers B this cycle
- ack_b  output  1  buffer B can accept; transfer when req_b && ack_b
- SEL  output  1  source of the word on Saida (0 = A, 1 = B)
- Saida  output  N  word on the channel
- saida_valida  output  1  Saida/SEL hold a valid word
- canal_pronto  input  1  channel consumes the word; transfer when saida_valida && canal_pronto

Behaviour:
- Reset (synchronous, active-high; dominates all other inputs, including mid-transfer):
  - Both buffers are emptied.
  - saida_valida=0, Saida=0, SEL=0.
  - Priority pointer points to A.
  - FSM goes to OCIOSO.
  - Any word in flight is discarded.
- Input buffers:
  - ack_x = !cheio_x (registered flag only; no combinational path from canal_pronto).
  - On req_x && ack_x, the word is captured and cheio_x is set at the next edge.
  - A buffer being drained this cycle does not accept in the same cycle; ack rises one cycle after drain. Each source therefore sustains at most one word every 2 cycles.
- FSM states:
  - OCIOSO: saida_valida=0.
  - ENVIA: saida_valida=1; Saida/SEL stable until consumed.
- Output register load condition: state is OCIOSO, or state is ENVIA with canal_pronto=1 (consumed this cycle).
- When the load condition holds:
  - Only one buffer full → that buffer is loaded.
  - Both full → the buffer the pointer names is loaded.
  - Load actions: Saida←word, SEL←source, cheio_source←0, pointer←other source, state→ENVIA.
  - Neither buffer full → state→OCIOSO and saida_valida drops. Saida/SEL keep their last values.
- Latency: a word accepted at edge k can appear on Saida after edge k+1 (one cycle minimum).
- Back-pressure: while saida_valida && !canal_pronto, Saida and SEL are held unchanged and no buffer is drained. Buffers still fill; ack falls when a buffer is full.
- Fairness: with both sources continuously requesting, the output sequence alternates A,B,A,B… starting with A after reset.
- A simultaneous drain of buffer X and a new req on X is not accepted that cycle (see ack rule).
- No word is lost or duplicated. Word order per source is preserved trivially, since each buffer holds one entry.

Optional Feature:
- Macro ROTEAMENTO_CONTADORES_EN.
- Defined:
  - Adds outputs cont_a[7:0] and cont_b[7:0].
  - Each counts words of its source consumed by the channel (saida_valida && canal_pronto, keyed by SEL).
  - Counters wrap 255→0 and are cleared by reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package roteamento_pkg holds:
  - parameter N=4
  - typedef palavra_t (logic [N-1:0])
  - typedef enum estado_t {OCIOSO, ENVIA}
  - constants FONTE_A=1'b0 and FONTE_B=1'b1
- The routing mux takes N from this package as well.
- One sub-module, buffer_entrada: one-entry buffer with req/ack in and cheio/dado/limpa out, instantiated twice.
- Arbitration, FSM and output register live in the top module.

Test Plan:
- Reset: after reset with req_a=1, A=4'h5, expect saida_valida=0, SEL=0, Saida=0, ack_a=1 during reset. Expect Saida=4'h5, SEL=0, saida_valida=1 two edges after reset is released.
- Single source B: B=4'hA, req_b pulsed one cycle, canal_pronto=1. Expect SEL=1, Saida=4'hA valid for exactly one cycle, then OCIOSO.
- Contention: both buffers loaded in the same cycle with A=4'h3, B=4'hC, canal_pronto=1. Expect 4'h3/SEL=0 then 4'hC/SEL=1. Repeat and expect strict alternation A,B,A,B.
- Back-pressure: canal_pronto=0 for 5 cycles while both sources request. Expect Saida/SEL unchanged, ack_a=ack_b=0 once both buffers are full, and no word lost after canal_pronto=1.
- Reset mid-operation: assert reset while saida_valida=1 and both buffers full. Expect everything cleared the next edge and the pointer back at A.
- With ROTEAMENTO_CONTADORES_EN: 256 consumed A words → cont_a=0 (wrap), cont_b unchanged.
